// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR + R) between two burst requesters.
// One burst is in flight at a time; the grant is held from AR acceptance until the RLAST beat.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,

    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,

    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,

    output logic [3:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  o_grant,
    output logic                  o_busy,
    output logic [1:0]            o_err
);

    localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state;
    logic       last_grant;
    logic [7:0] beat_cnt;
    logic       req_any;
    logic       req_sel;
    logic       in_data;
    logic       route0;
    logic       route1;
    logic       beat_fire;

    assign m_axi_arid    = 4'd0;
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

    // Under contention the port that did not win last time is chosen.
    always_comb begin
        req_any = s0_arvalid | s1_arvalid;
        req_sel = (s0_arvalid && s1_arvalid) ? ~last_grant : s1_arvalid;
    end

    assign s0_arready = (state == IDLE) && req_any && !req_sel;
    assign s1_arready = (state == IDLE) && req_any &&  req_sel;

    assign in_data      = (state == DATA);
    assign route0       = in_data && !o_grant;
    assign route1       = in_data &&  o_grant;
    assign m_axi_rready = in_data && (o_grant ? s1_rready : s0_rready);
    assign beat_fire    = m_axi_rvalid && m_axi_rready;
    assign o_busy       = (state != IDLE);

    assign s0_rvalid = route0 && m_axi_rvalid;
    assign s0_rdata  = route0 ? m_axi_rdata : '0;
    assign s0_rresp  = route0 ? m_axi_rresp : 2'b00;
    assign s0_rlast  = route0 && m_axi_rlast;
    assign s1_rvalid = route1 && m_axi_rvalid;
    assign s1_rdata  = route1 ? m_axi_rdata : '0;
    assign s1_rresp  = route1 ? m_axi_rresp : 2'b00;
    assign s1_rlast  = route1 && m_axi_rlast;

    // beat_cnt counts beats already accepted, so on the RLAST beat it must equal arlen.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            o_grant       <= 1'b0;
            o_err         <= 2'b00;
            beat_cnt      <= 8'd0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= 8'd0;
            m_axi_arvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        m_axi_araddr  <= req_sel ? s1_araddr : s0_araddr;
                        m_axi_arlen   <= req_sel ? s1_arlen : s0_arlen;
                        o_grant       <= req_sel;
                        last_grant    <= req_sel;
                        m_axi_arvalid <= 1'b1;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (m_axi_rresp != 2'b00) begin
                            o_err[1] <= 1'b1;
                        end
                        if (m_axi_rlast) begin
                            if (beat_cnt != m_axi_arlen) begin
                                o_err[0] <= 1'b1;
                            end
                            beat_cnt <= 8'd0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: requesters and an AXI slave model drive traffic,
// a negedge monitor pops expected grants, AR beats and R beats from queues and compares.
module tb_axi_rd_arbiter;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    typedef struct {
        int          port;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s0_araddr, s1_araddr;
    logic [7:0]  s0_arlen, s1_arlen;
    logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic [63:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
    logic        s0_rready, s1_rready;
    logic [3:0]  m_axi_arid, m_axi_arcache, m_axi_arqos;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        o_grant, o_busy;
    logic [1:0]  o_err;

    req_t  req_q0[$];
    req_t  req_q1[$];
    int    exp_grant_q[$];
    req_t  exp_ar_q[$];
    beat_t exp_beat_q[$];

    int checks = 0;
    int failures = 0;
    int beats_seen = 0;
    int ar_count = 0;

    logic        got_rdy0 = 1'b0, got_rdy1 = 1'b0;
    logic        ar_hs = 1'b0, r_hs = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [7:0]  cap_len = '0;
    int          slv_ar_delay = 0;
    int          slv_last_idx = -1;
    int          slv_bad_beat = -1;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
        .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
        .s1_rready(s1_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .o_grant(o_grant), .o_busy(o_busy), .o_err(o_err)
    );

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Queue a request for a port and the grant, AR and beats it must produce (beat data = addr + index).
    task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [7:0] len,
                                 input int last_idx, input int bad_beat);
        req_t  r;
        beat_t b;
        int    nb;
        r.port = port;
        r.addr = addr;
        r.len  = len;
        if (port == 0) req_q0.push_back(r);
        else           req_q1.push_back(r);
        exp_grant_q.push_back(port);
        exp_ar_q.push_back(r);
        nb = (last_idx < 0) ? int'(len) : last_idx;
        for (int i = 0; i <= nb; i++) begin
            b.port = port;
            b.data = 64'(addr) + 64'(i);
            b.resp = (i == bad_beat) ? 2'b10 : 2'b00;
            b.last = (i == nb);
            exp_beat_q.push_back(b);
        end
    endtask

    task automatic waitIdle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_beat_q.size() == 0 && exp_ar_q.size() == 0 && exp_grant_q.size() == 0 &&
                req_q0.size() == 0 && req_q1.size() == 0 && !s0_arvalid && !s1_arvalid && !o_busy) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput({"drain_", name}, 96'(done), 96'(1));
    endtask

    task automatic waitBeats(input int target, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (beats_seen >= target) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("wait_beats", 96'(done), 96'(1));
    endtask

    // Requesters: hold arvalid until the arready pulse, then scramble the address.
    initial begin
        req_t r;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        s0_araddr = '0; s1_araddr = '0; s0_arlen = '0; s1_arlen = '0;
        forever begin
            @(posedge clk); #1;
            if (s0_arvalid && got_rdy0) begin
                s0_arvalid = 1'b0; s0_araddr = 32'hDEAD_BEEF; s0_arlen = 8'hAA;
            end else if (!s0_arvalid && req_q0.size() > 0) begin
                r = req_q0.pop_front();
                s0_araddr = r.addr; s0_arlen = r.len; s0_arvalid = 1'b1;
            end
            if (s1_arvalid && got_rdy1) begin
                s1_arvalid = 1'b0; s1_araddr = 32'hDEAD_BEEF; s1_arlen = 8'hAA;
            end else if (!s1_arvalid && req_q1.size() > 0) begin
                r = req_q1.pop_front();
                s1_araddr = r.addr; s1_arlen = r.len; s1_arvalid = 1'b1;
            end
        end
    end

    // AXI slave model: optional arready stall, early rlast and an error response beat.
    initial begin
        int ss, wait_cnt, beat, last_idx;
        ss = 0; wait_cnt = 0; beat = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rdata = '0; m_axi_rresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                ss = 0; wait_cnt = 0; beat = 0;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
            end else begin
                if (ss == 2 && r_hs) begin
                    if (m_axi_rlast) begin
                        ss = 0; wait_cnt = 0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                    end else begin
                        beat++;
                    end
                end
                if (ss == 1 && ar_hs) begin
                    ss = 2; beat = 0; m_axi_arready = 1'b0;
                end
                if (ss == 0 && m_axi_arvalid) begin
                    if (wait_cnt >= slv_ar_delay) begin
                        m_axi_arready = 1'b1; ss = 1;
                    end else begin
                        wait_cnt++;
                    end
                end
                if (ss == 2) begin
                    last_idx     = (slv_last_idx < 0) ? int'(cap_len) : slv_last_idx;
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = 64'(cap_addr) + 64'(beat);
                    m_axi_rresp  = (beat == slv_bad_beat) ? 2'b10 : 2'b00;
                    m_axi_rlast  = (beat == last_idx);
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int    g;
        int    port;
        logic  outstanding;
        logic  prev_rdy;
        req_t  a;
        beat_t b;
        outstanding = 1'b0;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            got_rdy0 = s0_arready;
            got_rdy1 = s1_arready;
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            if (ar_hs) begin
                cap_addr = m_axi_araddr;
                cap_len  = m_axi_arlen;
            end
            if (!rst_n) begin
                outstanding = 1'b0;
                prev_rdy = 1'b0;
            end else begin
                if (s0_arready || s1_arready) begin
                    checkOutput("grant_expected", 96'(exp_grant_q.size() > 0), 96'(1));
                    checkOutput("arready_pulse", 96'(prev_rdy), 96'(0));
                    if (exp_grant_q.size() > 0) begin
                        g = exp_grant_q.pop_front();
                        checkOutput("grant_port", {s1_arready, s0_arready}, (g == 1) ? 96'd2 : 96'd1);
                    end
                end
                prev_rdy = s0_arready | s1_arready;
                if (m_axi_arvalid) begin
                    checkOutput("ar_expected", 96'(exp_ar_q.size() > 0), 96'(1));
                    if (exp_ar_q.size() > 0) begin
                        a = exp_ar_q[0];
                        checkOutput("araddr", 96'(m_axi_araddr), 96'(a.addr));
                        checkOutput("arlen", 96'(m_axi_arlen), 96'(a.len));
                        if (m_axi_arready) begin
                            checkOutput("arsize", 96'(m_axi_arsize), 96'(3));
                            checkOutput("ar_overlap", 96'(outstanding), 96'(0));
                            checkOutput("ar_grant", 96'(o_grant), 96'(a.port));
                            void'(exp_ar_q.pop_front());
                            outstanding = 1'b1;
                            ar_count++;
                        end
                    end
                end
                if ((s0_rvalid && s0_rready) || (s1_rvalid && s1_rready)) begin
                    port = s1_rvalid ? 1 : 0;
                    checkOutput("beat_expected", 96'(exp_beat_q.size() > 0), 96'(1));
                    if (port == 0)
                        checkOutput("idle_port_zero", {s1_rvalid, s1_rlast, s1_rresp, s1_rdata}, 96'(0));
                    else
                        checkOutput("idle_port_zero", {s0_rvalid, s0_rlast, s0_rresp, s0_rdata}, 96'(0));
                    if (exp_beat_q.size() > 0) begin
                        b = exp_beat_q.pop_front();
                        checkOutput("beat_port", 96'(port), 96'(b.port));
                        checkOutput("beat_data", port ? s1_rdata : s0_rdata, 96'(b.data));
                        checkOutput("beat_resp", 96'(port ? s1_rresp : s0_rresp), 96'(b.resp));
                        checkOutput("beat_last", 96'(port ? s1_rlast : s0_rlast), 96'(b.last));
                    end
                    beats_seen++;
                    if (s0_rlast || s1_rlast) outstanding = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int stall;
        rst_n = 1'b0;
        s0_rready = 1'b1;
        s1_rready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 96'(o_busy), 96'(0));
        checkOutput("reset_grant", 96'(o_grant), 96'(0));
        checkOutput("reset_err", 96'(o_err), 96'(0));
        checkOutput("reset_arvalid", 96'(m_axi_arvalid), 96'(0));
        checkOutput("reset_araddr", 96'(m_axi_araddr), 96'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] T1 single port 0 burst");
        applyStimulus(0, 32'h0000_1000, 8'd15, -1, -1);
        waitIdle("t1", 200);
        checkOutput("t1_err", 96'(o_err), 96'(0));
        checkOutput("t1_grant", 96'(o_grant), 96'(0));

        $display("[TB] single port 1 burst");
        applyStimulus(1, 32'h0000_1800, 8'd2, -1, -1);
        waitIdle("t1b", 100);
        checkOutput("t1b_grant", 96'(o_grant), 96'(1));

        $display("[TB] T2 contention, alternating grants");
        base = ar_count;
        applyStimulus(0, 32'h0000_2000, 8'd3, -1, -1);
        applyStimulus(1, 32'h0000_2800, 8'd3, -1, -1);
        applyStimulus(0, 32'h0000_2100, 8'd3, -1, -1);
        applyStimulus(1, 32'h0000_2900, 8'd3, -1, -1);
        applyStimulus(0, 32'h0000_2200, 8'd3, -1, -1);
        applyStimulus(1, 32'h0000_2A00, 8'd3, -1, -1);
        waitIdle("t2", 400);
        checkOutput("t2_ar_count", 96'(ar_count - base), 96'(6));
        checkOutput("t2_err", 96'(o_err), 96'(0));

        $display("[TB] T3 requester backpressure");
        base = beats_seen;
        applyStimulus(0, 32'h0000_4000, 8'd15, -1, -1);
        waitBeats(base + 5, 100);
        s0_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t3_m_rready_low", 96'(m_axi_rready), 96'(0));
            checkOutput("t3_rvalid_held", 96'(s0_rvalid), 96'(1));
            @(posedge clk); #1;
        end
        s0_rready = 1'b1;
        waitIdle("t3", 200);
        checkOutput("t3_beats", 96'(beats_seen - base), 96'(16));

        $display("[TB] T5 AR stall");
        slv_ar_delay = 10;
        applyStimulus(0, 32'h0000_5000, 8'd3, -1, -1);
        stall = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_axi_arvalid && !m_axi_arready) stall++;
            if (m_axi_arvalid && m_axi_arready) break;
        end
        checkOutput("t5_stall_cycles", 96'(stall), 96'(10));
        waitIdle("t5", 100);
        slv_ar_delay = 0;

        $display("[TB] T4 short burst and error response");
        slv_last_idx = 5;
        applyStimulus(1, 32'h0000_6000, 8'd7, 5, -1);
        waitIdle("t4a", 100);
        checkOutput("t4_len_err", 96'(o_err), 96'(2'b01));
        slv_last_idx = -1;
        slv_bad_beat = 2;
        applyStimulus(0, 32'h0000_6100, 8'd3, -1, 2);
        waitIdle("t4b", 100);
        checkOutput("t4_resp_err", 96'(o_err), 96'(2'b11));
        slv_bad_beat = -1;
        applyStimulus(1, 32'h0000_6200, 8'd1, -1, -1);
        waitIdle("t4c", 100);
        checkOutput("t4_err_sticky", 96'(o_err), 96'(2'b11));

        $display("[TB] T6 reset mid-burst");
        base = beats_seen;
        applyStimulus(0, 32'h0000_7000, 8'd15, -1, -1);
        waitBeats(base + 3, 100);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_busy", 96'(o_busy), 96'(0));
        checkOutput("t6_rready", 96'(m_axi_rready), 96'(0));
        checkOutput("t6_s0_rvalid", 96'(s0_rvalid), 96'(0));
        checkOutput("t6_s0_rdata", 96'(s0_rdata), 96'(0));
        checkOutput("t6_grant", 96'(o_grant), 96'(0));
        checkOutput("t6_err", 96'(o_err), 96'(0));
        checkOutput("t6_beats_before_reset", 96'(beats_seen - base), 96'(3));
        exp_beat_q.delete();
        exp_ar_q.delete();
        exp_grant_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, 32'h0000_7100, 8'd1, -1, -1);
        applyStimulus(1, 32'h0000_7200, 8'd1, -1, -1);
        waitIdle("t6", 100);
        checkOutput("t6_final_grant", 96'(o_grant), 96'(1));
        checkOutput("t6_final_err", 96'(o_err), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
